// File: rtl/wb_stream_writer_ctrl.sv
// Wishbone B3 burst-read master that fetches a buffer into a local FIFO and
// replays it on a valid/ready stream port (memory-to-stream DMA playback).
module wb_stream_writer_ctrl #(
  parameter int unsigned WB_AW         = 32,
  parameter int unsigned WB_DW         = 32,
  parameter int unsigned FIFO_AW       = 6,
  parameter int unsigned MAX_BURST_LEN = 16
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_ni,
  output logic [WB_AW-1:0]   wbm_adr_o,
  output logic [WB_DW/8-1:0] wbm_sel_o,
  output logic               wbm_we_o,
  output logic               wbm_cyc_o,
  output logic               wbm_stb_o,
  output logic [2:0]         wbm_cti_o,
  output logic [1:0]         wbm_bte_o,
  input  logic [WB_DW-1:0]   wbm_dat_i,
  input  logic               wbm_ack_i,
  input  logic               wbm_err_i,
  output logic [WB_DW-1:0]   stream_data,
  output logic               stream_valid,
  input  logic               stream_ready,
  input  logic               enable,
  input  logic [WB_AW-1:0]   start_adr,
  input  logic [WB_AW-1:0]   buf_size,
  input  logic [WB_AW-1:0]   burst_size,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [WB_DW-1:0]   tx_cnt
);

  localparam int unsigned       Depth    = 1 << FIFO_AW;
  localparam logic [WB_AW-1:0]  AdrStep  = WB_AW'(WB_DW / 8);
  localparam logic [WB_AW-1:0]  AdrMask  = ~(WB_AW'(WB_DW / 8 - 1));
  localparam logic [WB_AW-1:0]  AwOne    = WB_AW'(1);
  localparam logic [WB_AW-1:0]  MaxLen   = WB_AW'(MAX_BURST_LEN);
  localparam logic [WB_AW-1:0]  DepthAw  = WB_AW'(Depth);
  localparam logic [FIFO_AW:0]  CntOne   = (FIFO_AW + 1)'(1);
  localparam logic [FIFO_AW:0]  CntDepth = (FIFO_AW + 1)'(Depth);
  localparam logic [WB_DW-1:0]  TxOne    = WB_DW'(1);

  typedef enum logic [2:0] {
    StIdle, StWait, StBurst, StDrain, StDone, StError
  } state_e;

  state_e             r_state, w_state_d;
  logic [WB_AW-1:0]   r_adr;
  logic [WB_AW-1:0]   r_rem;
  logic [WB_AW-1:0]   r_beats;
  logic [WB_DW-1:0]   r_tx_cnt;

  logic [WB_DW-1:0]   r_mem [Depth];
  logic [FIFO_AW-1:0] r_wptr;
  logic [FIFO_AW-1:0] r_rptr;
  logic [FIFO_AW:0]   r_count;

  logic [WB_AW-1:0]   w_len;
  logic [FIFO_AW:0]   w_free;
  logic               w_push;
  logic               w_pop;

  // Burst length is also capped by FIFO depth so a small FIFO can never stall forever.
  always_comb begin
    w_len = (burst_size == '0) ? AwOne : burst_size;
    if (r_rem < w_len)   w_len = r_rem;
    if (MaxLen < w_len)  w_len = MaxLen;
    if (DepthAw < w_len) w_len = DepthAw;
  end

  assign w_free = CntDepth - r_count;
  assign w_push = (r_state == StBurst) && enable && wbm_ack_i && !wbm_err_i;
  assign w_pop  = stream_valid && stream_ready;

  always_comb begin
    w_state_d = r_state;
    case (r_state)
      StIdle: begin
        if (enable) w_state_d = (buf_size == '0) ? StDone : StWait;
      end
      StWait: begin
        if (!enable)                        w_state_d = StIdle;
        else if (WB_AW'(w_free) >= w_len)   w_state_d = StBurst;
      end
      StBurst: begin
        if (!enable)        w_state_d = StIdle;
        else if (wbm_err_i) w_state_d = StError;
        else if (wbm_ack_i && r_beats == AwOne) begin
          w_state_d = (r_rem == AwOne) ? StDrain : StWait;
        end
      end
      StDrain: begin
        if (!enable)               w_state_d = StIdle;
        else if (r_count == '0)    w_state_d = StDone;
      end
      StDone, StError: begin
        if (!enable) w_state_d = StIdle;
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_state  <= StIdle;
      r_adr    <= '0;
      r_rem    <= '0;
      r_beats  <= '0;
      r_tx_cnt <= '0;
    end else begin
      r_state <= w_state_d;
      if (r_state == StIdle && enable) begin
        r_adr <= start_adr & AdrMask;
        r_rem <= buf_size;
      end else if (w_push) begin
        r_adr <= r_adr + AdrStep;
        r_rem <= r_rem - AwOne;
      end
      if (r_state == StWait && w_state_d == StBurst) begin
        r_beats <= w_len;
      end else if (w_push) begin
        r_beats <= r_beats - AwOne;
      end
      if (r_state == StIdle && enable) begin
        r_tx_cnt <= '0;
      end else if (w_pop) begin
        r_tx_cnt <= r_tx_cnt + TxOne;
      end
    end
  end

  // Dropping enable flushes the FIFO; pushes are already gated by enable.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (!enable) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CntOne;
        2'b01:   r_count <= r_count - CntOne;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (w_push) r_mem[r_wptr] <= wbm_dat_i;
  end

  assign wbm_adr_o    = r_adr;
  assign wbm_sel_o    = '1;
  assign wbm_we_o     = 1'b0;
  assign wbm_bte_o    = 2'b00;
  assign wbm_cyc_o    = (r_state == StBurst);
  assign wbm_stb_o    = wbm_cyc_o;
  assign wbm_cti_o    = !wbm_cyc_o ? 3'b000 : (r_beats == AwOne) ? 3'b111 : 3'b010;

  assign stream_valid = (r_count != '0);
  assign stream_data  = r_mem[r_rptr];

  assign busy   = (r_state == StWait) || (r_state == StBurst) || (r_state == StDrain);
  assign done   = (r_state == StDone);
  assign err    = (r_state == StError);
  assign tx_cnt = r_tx_cnt;

`ifndef SYNTHESIS
  a_no_overflow: assert property (@(posedge wb_clk_i) disable iff (!wb_rst_ni)
    !(w_push && !w_pop && r_count == CntDepth));
`endif

endmodule

// File: tb/tb_wb_stream_writer_ctrl.sv
// Directed + randomized bench for wb_stream_writer_ctrl with a queue-based
// reference of expected bus beats and stream words.
module tb_wb_stream_writer_ctrl;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned MAXB  = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] adr;
  logic [3:0]  sel;
  logic        we, cyc, stb;
  logic [2:0]  cti;
  logic [1:0]  bte;
  logic [31:0] dat = '0;
  logic        ack = 1'b0, err_i = 1'b0;
  logic [31:0] sdata;
  logic        svalid;
  logic        sready = 1'b0;
  logic        enable = 1'b0;
  logic [31:0] start_adr = '0, buf_size = '0, burst_size = '0;
  logic        busy, done, err;
  logic [31:0] tx_cnt;

  wb_stream_writer_ctrl #(.FIFO_AW(3)) dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n),
    .wbm_adr_o(adr), .wbm_sel_o(sel), .wbm_we_o(we), .wbm_cyc_o(cyc), .wbm_stb_o(stb),
    .wbm_cti_o(cti), .wbm_bte_o(bte), .wbm_dat_i(dat), .wbm_ack_i(ack), .wbm_err_i(err_i),
    .stream_data(sdata), .stream_valid(svalid), .stream_ready(sready),
    .enable(enable), .start_adr(start_adr), .buf_size(buf_size), .burst_size(burst_size),
    .busy(busy), .done(done), .err(err), .tx_cnt(tx_cnt)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] salt;
  logic [31:0] exp_adr[$];
  logic [2:0]  exp_cti[$];
  logic [31:0] exp_word[$];
  int          nbeats = 0;
  int          exp_tx = 0;
  int          err_beat = 0;
  bit          cyc_seen = 0, ack_rand = 0, ready_en = 0, ready_rand = 0;
  bit          err_pending = 0, last_pending = 0;

  function automatic logic [31:0] memfn(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ salt;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Expected beat list: bursts of min(burst (0->1), remaining, MAXB, DEPTH) words.
  task automatic plan_run(input logic [31:0] start, input int unsigned len,
                          input int unsigned bsz);
    logic [31:0] a;
    int unsigned rem, l;
    a = start & ~32'h3;
    rem = len;
    exp_adr.delete();
    exp_cti.delete();
    exp_word.delete();
    while (rem > 0) begin
      l = (bsz == 0) ? 1 : bsz;
      if (l > rem) l = rem;
      if (l > MAXB) l = MAXB;
      if (l > DEPTH) l = DEPTH;
      for (int j = 0; j < int'(l); j++) begin
        exp_adr.push_back(a);
        exp_cti.push_back((j == int'(l) - 1) ? 3'b111 : 3'b010);
        a = a + 32'd4;
      end
      rem = rem - l;
    end
  endtask

  task automatic start_run(input logic [31:0] s, input int unsigned len,
                           input int unsigned bsz);
    @(posedge clk); #1;
    plan_run(s, len, bsz);
    nbeats = 0;
    exp_tx = 0;
    cyc_seen = 0;
    start_adr = s;
    buf_size = len;
    burst_size = bsz;
    enable = 1'b1;
  endtask

  task automatic wait_end(input int budget, input string tag);
    int n;
    n = 0;
    while (!(done || err) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_finished"}, 32'(done || err), 32'd1);
  endtask

  task automatic stop_run(input string tag);
    @(posedge clk); #1;
    enable = 1'b0;
    err_beat = 0;
    @(posedge clk);
    @(negedge clk);
    check({tag, "_busy_clr"}, 32'(busy), 32'd0);
    check({tag, "_done_clr"}, 32'(done), 32'd0);
    check({tag, "_err_clr"}, 32'(err), 32'd0);
  endtask

  task automatic end_checks(input string tag, input int unsigned len);
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_tx_cnt"}, tx_cnt, len);
    check({tag, "_tx_model"}, tx_cnt, 32'(exp_tx));
    check({tag, "_beats_left"}, 32'(exp_adr.size()), 32'd0);
    check({tag, "_words_left"}, 32'(exp_word.size()), 32'd0);
  endtask

  // Wishbone slave, stream consumer and scoreboard; inputs change on the falling edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      ack = 1'b0;
      err_i = 1'b0;
      sready = 1'b0;
    end else begin
      if (cyc) cyc_seen = 1;
      if (last_pending) begin
        check("cyc_drop_after_last", 32'(cyc), 32'd0);
        last_pending = 0;
      end
      if (err_pending) begin
        check("err_cyc", 32'(cyc), 32'd0);
        check("err_flag", 32'(err), 32'd1);
        check("err_busy", 32'(busy), 32'd0);
        err_pending = 0;
      end
      sready = ready_en && (!ready_rand || ($urandom_range(0, 1) == 1));
      ack = 1'b0;
      err_i = 1'b0;
      if (cyc) begin
        dat = memfn(adr);
        if (err_beat != 0 && nbeats + 1 == err_beat) err_i = 1'b1;
        else ack = !ack_rand || ($urandom_range(0, 2) != 0);
      end
      if (enable) begin
        if (svalid && sready) begin
          check("stream_word_expected", 32'(exp_word.size() != 0), 32'd1);
          if (exp_word.size() != 0) check("stream_data", sdata, exp_word.pop_front());
          exp_tx++;
        end
        if (cyc && err_i) begin
          err_pending = 1;
          err_beat = 0;
        end else if (cyc && ack) begin
          nbeats++;
          check("beat_expected", 32'(exp_adr.size() != 0), 32'd1);
          if (exp_adr.size() != 0) begin
            check("beat_adr", adr, exp_adr.pop_front());
            check("beat_cti", 32'(cti), 32'(exp_cti.pop_front()));
          end
          exp_word.push_back(memfn(adr));
          if (cti == 3'b111) last_pending = 1;
        end
      end
    end
  end

  initial begin
    int n;
    salt = $urandom;
    repeat (3) @(posedge clk);
    #1;
    check("rst_cyc", 32'(cyc), 32'd0);
    check("rst_stb", 32'(stb), 32'd0);
    check("rst_cti", 32'(cti), 32'd0);
    check("rst_adr", adr, 32'd0);
    check("rst_valid", 32'(svalid), 32'd0);
    check("rst_flags", {29'd0, busy, done, err}, 32'd0);
    check("rst_tx_cnt", tx_cnt, 32'd0);
    check("tie_sel_we_bte", {25'd0, sel, we, bte}, {25'd0, 4'hF, 1'b0, 2'b00});
    rst_n = 1'b1;

    // 1: two bursts of four, ack and ready every cycle
    ack_rand = 0; ready_en = 1; ready_rand = 0;
    start_run(32'h1000, 8, 4);
    wait_end(500, "t1");
    end_checks("t1", 8);
    stop_run("t1");

    // 2: consumer stalled, fetch limited by FIFO space
    ready_en = 0; ack_rand = 1;
    start_run(32'h2000, 20, 4);
    repeat (100) @(negedge clk);
    check("t2_fetched", 32'(nbeats), 32'd8);
    check("t2_cyc_idle", 32'(cyc), 32'd0);
    check("t2_busy", 32'(busy), 32'd1);
    ready_en = 1; ready_rand = 1;
    wait_end(2000, "t2");
    end_checks("t2", 20);
    stop_run("t2");

    // 3: 4+1 split with unaligned start, then zero-length run
    start_run(32'h3002, 5, 4);
    wait_end(500, "t3");
    end_checks("t3", 5);
    stop_run("t3");
    start_run(32'h4000, 0, 4);
    @(posedge clk);
    @(negedge clk);
    check("t3z_done", 32'(done), 32'd1);
    check("t3z_busy", 32'(busy), 32'd0);
    repeat (5) @(negedge clk);
    check("t3z_no_cyc", 32'(cyc_seen), 32'd0);
    check("t3z_tx_cnt", tx_cnt, 32'd0);
    stop_run("t3z");

    // 4: bus error on the third beat of four
    ready_en = 0; ack_rand = 0; err_beat = 3;
    start_run(32'h5000, 8, 4);
    wait_end(200, "t4");
    check("t4_err", 32'(err), 32'd1);
    check("t4_fetched", 32'(nbeats), 32'd2);
    ready_en = 1; ready_rand = 0;
    repeat (10) @(negedge clk);
    check("t4_tx_cnt", tx_cnt, 32'd2);
    check("t4_drained", 32'(svalid), 32'd0);
    check("t4_err_held", 32'(err), 32'd1);
    stop_run("t4");

    // 5: abort mid-burst, then restart
    ready_en = 1; ready_rand = 1; ack_rand = 0;
    start_run(32'h6000, 12, 4);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!(cyc && nbeats >= 5 && svalid) && n < 200);
    check("t5_reached_burst", 32'(cyc && svalid), 32'd1);
    enable = 1'b0;
    exp_adr.delete(); exp_cti.delete(); exp_word.delete();
    @(posedge clk);
    @(negedge clk);
    check("t5_abort_cyc", 32'(cyc), 32'd0);
    check("t5_abort_valid", 32'(svalid), 32'd0);
    check("t5_abort_flags", {29'd0, busy, done, err}, 32'd0);
    start_run(32'h6000, 12, 4);
    @(posedge clk);
    @(negedge clk);
    check("t5_restart_tx", tx_cnt, 32'd0);
    check("t5_restart_busy", 32'(busy), 32'd1);
    wait_end(1000, "t5");
    end_checks("t5", 12);
    stop_run("t5");

    // 6: asynchronous reset between edges during a burst
    ack_rand = 1;
    start_run(32'h7000, 16, 8);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!cyc && n < 200);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rst_cyc", 32'(cyc), 32'd0);
    check("t6_rst_valid", 32'(svalid), 32'd0);
    check("t6_rst_busy", 32'(busy), 32'd0);
    enable = 1'b0;
    exp_adr.delete(); exp_cti.delete(); exp_word.delete();
    last_pending = 0; err_pending = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;

    // randomized runs
    for (int r = 0; r < 4; r++) begin
      int unsigned len, bsz;
      logic [31:0] s;
      s = $urandom & 32'h00FF_FFFF;
      len = $urandom_range(1, 24);
      bsz = $urandom_range(0, 20);
      ack_rand = 1; ready_en = 1; ready_rand = 1;
      start_run(s, len, bsz);
      wait_end(3000, "rnd");
      end_checks("rnd", len);
      stop_run("rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
